// File: rtl/high_run_gen.sv
// Burst generator: emits `count` high runs of HIGH_CYCLES on x, separated by
// GAP_CYCLES low cycles, then a one-cycle done pulse. Abortable, async active-low reset.
module high_run_gen #(
  parameter int HIGH_CYCLES = 3,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] count,
  input  logic       abort,
  output logic       x,
  output logic       busy,
  output logic       done,
  output logic [7:0] runs_left
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [7:0] HIGH_LAST = 8'(HIGH_CYCLES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] runs_left_q, runs_left_d;
  logic       x_q, x_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    runs_left_d = runs_left_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          if (count != 8'd0) begin
            state_d     = S_HIGH;
            runs_left_d = count - 8'd1;
          end else begin
            state_d     = S_DONE;
            runs_left_d = '0;
          end
        end
      end
      S_HIGH: begin
        if (abort) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          runs_left_d = '0;
        end else if (cnt_q == HIGH_LAST) begin
          cnt_d   = '0;
          state_d = (runs_left_q != 8'd0) ? S_GAP : S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          runs_left_d = '0;
        end else if (cnt_q == GAP_LAST) begin
          // runs_left counts down on re-entry to HIGH, not when the run ends
          cnt_d       = '0;
          state_d     = S_HIGH;
          runs_left_d = runs_left_q - 8'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered copies of next-state decodes so they align with state_q.
  always_comb begin
    x_d    = (state_d == S_HIGH);
    busy_d = (state_d == S_HIGH) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      runs_left_q <= '0;
      x_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      runs_left_q <= runs_left_d;
      x_q         <= x_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign x         = x_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign runs_left = runs_left_q;

endmodule

// File: tb/tb_high_run_gen.sv
// Scoreboard bench for high_run_gen: the driver pushes the per-cycle expected
// output trace of each burst; a negedge monitor pops and compares every cycle.
module tb_high_run_gen;

  localparam int HC = 3;
  localparam int GC = 1;

  typedef struct packed {
    logic       x;
    logic       busy;
    logic       done;
    logic [7:0] rl;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] count = '0;
  logic       abort = 1'b0;
  logic       x, busy, done;
  logic [7:0] runs_left;

  obs_t sb[$];
  bit   mon_en = 1'b0;
  int   total = 0;
  int   bad = 0;

  high_run_gen #(.HIGH_CYCLES(HC), .GAP_CYCLES(GC)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .abort(abort),
    .x(x), .busy(busy), .done(done), .runs_left(runs_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = '{x: x, busy: busy, done: done, rl: runs_left};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t: got x=%b busy=%b done=%b runs_left=%0d, want x=%b busy=%b done=%b runs_left=%0d",
               name, $time, act.x, act.busy, act.done, act.rl, exp.x, exp.busy, exp.done, exp.rl);
    end
  endtask

  always @(negedge clk) begin
    obs_t e;
    if (mon_en) begin
      e = '0;
      if (sb.size() != 0) e = sb.pop_front();
      check("cycle", e);
    end
  end

  // Expected per-cycle trace of a burst, cycle 1 first (cycle 1 follows the start edge).
  function automatic void build_trace(input int cnt, output obs_t tr[$]);
    tr = {};
    for (int r = 0; r < cnt; r++) begin
      for (int h = 0; h < HC; h++) tr.push_back('{1'b1, 1'b1, 1'b0, 8'(cnt - 1 - r)});
      if (r < cnt - 1)
        for (int g = 0; g < GC; g++) tr.push_back('{1'b0, 1'b1, 1'b0, 8'(cnt - 1 - r)});
    end
    tr.push_back('{1'b0, 1'b0, 1'b1, 8'd0});
  endfunction

  // abort_at: edge number (1-based) at which abort is sampled; 0 = none.
  task automatic burst(input int cnt, input int abort_at_in, input bit spur, input bit abort_with_start);
    obs_t tr[$];
    int   abort_at;
    int   len;
    build_trace(cnt, tr);
    abort_at = 0;
    if (abort_at_in > 0 && abort_at_in <= tr.size())
      if (tr[abort_at_in-1].busy) abort_at = abort_at_in;
    if (abort_at != 0) while (tr.size() > abort_at) void'(tr.pop_back());
    len = tr.size();
    @(negedge clk);
    start = 1'b1;
    count = 8'(cnt);
    abort = abort_with_start;
    @(posedge clk);
    foreach (tr[i]) sb.push_back(tr[i]);
    for (int e = 1; e <= len; e++) begin
      @(negedge clk);
      start = spur && ($urandom_range(2) == 0);
      count = 8'($urandom);
      abort = (e == abort_at);
      @(posedge clk);
    end
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      abort = $urandom_range(1);
      @(posedge clk);
    end
    #1;
    abort = 1'b0;
  endtask

  initial begin
    // Reset state, with no clock edge yet and then across several edges.
    #3 check("reset_noclk", '0);
    start = 1'b1;
    count = 8'd4;
    repeat (3) @(negedge clk);
    check("reset_held", '0);
    start = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    mon_en = 1'b1;

    burst(1, 0, 1'b0, 1'b0);
    burst(2, 0, 1'b0, 1'b0);
    burst(0, 0, 1'b0, 1'b0);
    idle(2);
    burst(3, 2, 1'b0, 1'b0);
    burst(2, 0, 1'b0, 1'b0);
    burst(1, 0, 1'b1, 1'b0);
    burst(3, 0, 1'b0, 1'b1);
    burst(3, 5, 1'b0, 1'b0);
    burst(255, 0, 1'b1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int c;
      int a;
      c = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(1, 6));
      a = ($urandom_range(3) == 0) ? int'($urandom_range(1, 20)) : 0;
      burst(c, a, $urandom_range(1), $urandom_range(1));
      if ($urandom_range(1) == 1) idle(int'($urandom_range(1, 3)));
    end

    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      bad++;
      total++;
      $display("FAIL drain: %0d expected cycles left, want 0", sb.size());
    end

    // Async reset mid-burst, then start honoured on the first edge after release.
    @(negedge clk);
    mon_en = 1'b0;
    sb.delete();
    start = 1'b1;
    count = 8'd3;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 check("pre_reset_cycle2", '{1'b1, 1'b1, 1'b0, 8'd2});
    #2 rst = 1'b0;
    #1 check("async_drop", '0);
    repeat (3) begin
      @(negedge clk);
      start = 1'b1;
      check("reset_hold", '0);
    end
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    count = 8'd1;
    begin
      obs_t tr[$];
      build_trace(1, tr);
      @(posedge clk);
      foreach (tr[i]) sb.push_back(tr[i]);
      mon_en = 1'b1;
    end
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    if (sb.size() != 0) begin
      bad++;
      total++;
      $display("FAIL post_reset_drain: %0d expected cycles left, want 0", sb.size());
    end
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
